// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle between the UART RX engine and its consumer.
// The engine drives the word, flags and Busy; the consumer drives Rx_Ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Rx_Data;
    logic                 Rx_Valid;
    logic                 Rx_Ready;
    logic                 Parity_Err;
    logic                 Frame_Err;
    logic                 Overrun_Err;
    logic                 Busy;

    modport master (
        output Rx_Data, Rx_Valid, Parity_Err, Frame_Err, Overrun_Err, Busy,
        input  Rx_Ready
    );

    modport slave (
        input  Rx_Data, Rx_Valid, Parity_Err, Frame_Err, Overrun_Err, Busy,
        output Rx_Ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: 2-FF line sync, start-edge detect, mid-bit sampling,
// configurable data/parity/stop framing and a valid/ready output with error flags.
module uart_rx_core #(
    parameter int BIT_CYCLES = 10417,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_Pin_In,
    uart_rx_core_if.master   rx
);
    localparam int            CW   = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 s1, s2;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] sh;
    logic                 perr, ferr;
    logic                 fall, samp, bit_last, stop_last, done;

    assign fall = s2 & ~s1;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (samp) state_nxt = s2 ? IDLE : DATA;
            DATA:  if (samp && bit_last) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (samp) state_nxt = STOP;
            STOP:  if (samp && stop_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        samp      = (cnt == HALF);
        bit_last  = (bit_idx == 4'(DATA_BITS - 1));
        stop_last = (stop_idx == 1'(STOP_BITS - 1));
        done      = (state == STOP) && samp && stop_last;
        rx.Busy   = (state != IDLE);
    end

    // The bit timer free-runs from START entry, so every later mid-bit sample
    // lands exactly BIT_CYCLES after the validated start sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            sh       <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            s1 <= RX_Pin_In;
            s2 <= s1;
            if (state == IDLE) begin
                cnt      <= '0;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
            end else begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (samp) begin
                    case (state)
                        DATA: begin
                            sh      <= {s2, sh[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + 4'd1;
                        end
                        PAR:  perr <= (PARITY == 1) ? ~(^sh ^ s2) : (^sh ^ s2);
                        STOP: begin
                            ferr     <= ferr | ~s2;
                            stop_idx <= stop_idx + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // An accept in the same cycle as a completion frees the slot, so it loads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx.Rx_Data     <= '0;
            rx.Rx_Valid    <= 1'b0;
            rx.Parity_Err  <= 1'b0;
            rx.Frame_Err   <= 1'b0;
            rx.Overrun_Err <= 1'b0;
        end else begin
            rx.Overrun_Err <= 1'b0;
            if (done) begin
                if (!rx.Rx_Valid || rx.Rx_Ready) begin
                    rx.Rx_Data    <= sh;
                    rx.Rx_Valid   <= 1'b1;
                    rx.Parity_Err <= perr;
                    rx.Frame_Err  <= ferr | ~s2;
                end else begin
                    rx.Overrun_Err <= 1'b1;
                end
            end else if (rx.Rx_Valid && rx.Rx_Ready) begin
                rx.Rx_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: three receivers (8N1, 8E1, 7N2) each fed by its own line;
// expected words are queued at stimulus time and popped on each accepted handshake.
module tb_uart_rx_core;
    localparam int BC = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [2:0] line = 3'b111;
    int         total = 0, bad = 0;
    int         acc_cnt[3] = '{0, 0, 0};
    int         ovr_a = 0, busy_cnt = 0;
    exp_t       qa[$], qb[$], qc[$];
    exp_t       ea, eb, ec;

    uart_rx_core_if #(.DATA_BITS(8)) ifa ();
    uart_rx_core_if #(.DATA_BITS(8)) ifb ();
    uart_rx_core_if #(.DATA_BITS(7)) ifc ();

    uart_rx_core #(.BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.CLK(CLK), .RST(RST), .RX_Pin_In(line[0]), .rx(ifa));
    uart_rx_core #(.BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_b (.CLK(CLK), .RST(RST), .RX_Pin_In(line[1]), .rx(ifb));
    uart_rx_core #(.BIT_CYCLES(BC), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
        dut_c (.CLK(CLK), .RST(RST), .RX_Pin_In(line[2]), .rx(ifc));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s got=unexpected/timeout exp=none", nm);
    endtask

    task automatic push(input int ch, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e = '{d: d, pe: pe, fe: fe};
        case (ch)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int ch);
        return (ch == 0) ? qa.size() : (ch == 1) ? qb.size() : qc.size();
    endfunction

    task automatic drive(input int ch, input logic v);
        line[ch] = v;
        repeat (BC) @(negedge CLK);
    endtask

    task automatic send(input int ch, input logic [8:0] d, input int nd, input bit hp,
                        input logic pb, input int ns, input logic last_stop);
        drive(ch, 1'b0);
        for (int i = 0; i < nd; i++) drive(ch, d[i]);
        if (hp) drive(ch, pb);
        for (int i = 0; i < ns; i++) drive(ch, (i == ns - 1) ? last_stop : 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_drain(input int ch, input string nm);
        for (int i = 0; i < 400 && qsize(ch) != 0; i++) @(negedge CLK);
        if (qsize(ch) != 0) flag_fail(nm);
    endtask

    always @(negedge CLK) begin
        if (!RST && ifa.Rx_Valid && ifa.Rx_Ready) begin
            acc_cnt[0]++;
            if (qa.size() == 0) flag_fail("a_unexpected_word");
            else begin
                ea = qa.pop_front();
                chk("a_data", {1'b0, ifa.Rx_Data}, ea.d);
                chk("a_perr", {8'd0, ifa.Parity_Err}, {8'd0, ea.pe});
                chk("a_ferr", {8'd0, ifa.Frame_Err}, {8'd0, ea.fe});
            end
        end
        if (!RST && ifa.Overrun_Err) ovr_a++;
        if (ifa.Busy) busy_cnt++;
    end

    always @(negedge CLK) begin
        if (!RST && ifb.Rx_Valid && ifb.Rx_Ready) begin
            acc_cnt[1]++;
            if (qb.size() == 0) flag_fail("b_unexpected_word");
            else begin
                eb = qb.pop_front();
                chk("b_data", {1'b0, ifb.Rx_Data}, eb.d);
                chk("b_perr", {8'd0, ifb.Parity_Err}, {8'd0, eb.pe});
                chk("b_ferr", {8'd0, ifb.Frame_Err}, {8'd0, eb.fe});
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && ifc.Rx_Valid && ifc.Rx_Ready) begin
            acc_cnt[2]++;
            if (qc.size() == 0) flag_fail("c_unexpected_word");
            else begin
                ec = qc.pop_front();
                chk("c_data", {2'b0, ifc.Rx_Data}, ec.d);
                chk("c_perr", {8'd0, ifc.Parity_Err}, {8'd0, ec.pe});
                chk("c_ferr", {8'd0, ifc.Frame_Err}, {8'd0, ec.fe});
            end
        end
    end

    initial begin
        int a0, o0;
        ifa.Rx_Ready = 1'b1;
        ifb.Rx_Ready = 1'b1;
        ifc.Rx_Ready = 1'b1;
        idle(3);
        chk("rst_valid", {8'd0, ifa.Rx_Valid}, 9'd0);
        chk("rst_data",  {1'b0, ifa.Rx_Data}, 9'd0);
        chk("rst_perr",  {8'd0, ifa.Parity_Err}, 9'd0);
        chk("rst_ferr",  {8'd0, ifa.Frame_Err}, 9'd0);
        chk("rst_ovr",   {8'd0, ifa.Overrun_Err}, 9'd0);
        chk("rst_busy",  {8'd0, ifa.Busy}, 9'd0);
        RST = 1'b0;
        idle(4);

        // 8N1 clean frame
        push(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
        idle(2 * BC);
        wait_drain(0, "t1_timeout");

        // Even parity: 0x03 has even ones, so a parity bit of 1 is an error
        push(1, 9'h003, 1'b1, 1'b0);
        send(1, 9'h003, 8, 1, 1'b1, 1, 1'b1);
        push(1, 9'h003, 1'b0, 1'b0);
        send(1, 9'h003, 8, 1, 1'b0, 1, 1'b1);
        idle(2 * BC);
        wait_drain(1, "t2_timeout");

        // Frame error followed by a break: only one word may appear
        a0 = acc_cnt[0];
        push(0, 9'h05A, 1'b0, 1'b1);
        send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0);
        idle(40);
        line[0] = 1'b1;
        idle(2 * BC);
        wait_drain(0, "t3_timeout");
        chk("t3_single_word", 9'(acc_cnt[0] - a0), 9'd1);

        // Start glitch shorter than half a bit
        a0 = acc_cnt[0];
        busy_cnt = 0;
        line[0] = 1'b0;
        idle(5);
        line[0] = 1'b1;
        idle(3 * BC);
        chk("t4_busy_seen", {8'd0, 1'(busy_cnt >= 6 && busy_cnt <= 12)}, 9'd1);
        chk("t4_busy_low", {8'd0, ifa.Busy}, 9'd0);
        chk("t4_no_word", 9'(acc_cnt[0] - a0), 9'd0);

        // Overrun: consumer stalled across two back-to-back frames
        ifa.Rx_Ready = 1'b0;
        o0 = ovr_a;
        push(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 0, 1'b0, 1, 1'b1);
        send(0, 9'h022, 8, 0, 1'b0, 1, 1'b1);
        idle(2 * BC);
        chk("t5_ovr_pulses", 9'(ovr_a - o0), 9'd1);
        chk("t5_held_valid", {8'd0, ifa.Rx_Valid}, 9'd1);
        chk("t5_held_data", {1'b0, ifa.Rx_Data}, 9'h011);
        ifa.Rx_Ready = 1'b1;
        wait_drain(0, "t5_timeout");
        idle(2);
        chk("t5_valid_fell", {8'd0, ifa.Rx_Valid}, 9'd0);

        // 7N2 frames; the second has its final stop bit low
        push(2, 9'h055, 1'b0, 1'b0);
        send(2, 9'h055, 7, 0, 1'b0, 2, 1'b1);
        push(2, 9'h02A, 1'b0, 1'b1);
        send(2, 9'h02A, 7, 0, 1'b0, 2, 1'b0);
        line[2] = 1'b1;
        idle(2 * BC);
        wait_drain(2, "t7_timeout");

        // Reset in the middle of data bit 4 aborts the frame
        line[0] = 1'b0;
        idle(5 * BC + BC / 2);
        RST = 1'b1;
        idle(1);
        chk("t6_busy", {8'd0, ifa.Busy}, 9'd0);
        chk("t6_valid", {8'd0, ifa.Rx_Valid}, 9'd0);
        chk("t6_data", {1'b0, ifa.Rx_Data}, 9'd0);
        chk("t6_flags", {7'd0, ifa.Parity_Err, ifa.Frame_Err}, 9'd0);
        line[0] = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(2 * BC);
        push(0, 9'h0C3, 1'b0, 1'b0);
        send(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b1);
        idle(2 * BC);
        wait_drain(0, "t6_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
